onehot_rr_arbiter: RTL
======================

# onehot_rr_arbiter

Round-robin arbiter for eight request lines: accepts raw, possibly simultaneous requests and issues a registered one-hot grant, held until the consumer signals completion. Sits directly upstream of the 8-to-3 binary encoder; its `grant` vector drives the encoder's one-hot input, so the encoder always sees at most one asserted line.

## Interface
- `N_REQ`, 8: number of request lines. Fixed at 8 to match the encoder input.
- `TIMEOUT_CYCLES`, 15: watchdog limit in cycles, range 1..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 8: request lines, level-sensitive, bit i = requester i.
- `done`, in, 1: consumer finished with the current grant; sampled only in GRANT.
- `grant`, out, 8: registered one-hot grant; all zeros when idle.
- `grant_valid`, out, 1: high exactly when `grant` is non-zero.
- `timeout`, out, 1: one-cycle pulse when the watchdog releases a grant. Tied 0 when `ARB_TIMEOUT_EN` is undefined.

## Operation
- **Reset values:** `grant`=8'h00, `grant_valid`=0, `timeout`=0, pointer `ptr`=3'd0, state=IDLE, watchdog=0.
- **States:** IDLE and GRANT.
- **IDLE:**
  - If `req`==0, remain in IDLE.
  - Otherwise pick the winner: the first set bit scanning from `ptr` upward, wrapping 7→0.
  - Register `grant`=1<<winner, set `grant_valid`=1, go to GRANT.
- **GRANT:**
  - `grant` is frozen. Changes on `req`, including the winner dropping its request, have no effect.
  - On `done`=1: clear `grant` to 0, set `ptr`=(winner+1) mod 8 (3-bit wrap), return to IDLE.
  - `done` asserted in IDLE is ignored.
- **Fairness:** after requester k is served, k has the lowest priority for the next arbitration. With all eight lines held high, grants rotate 0,1,…,7,0.
- **Invariant:** `grant` is 0 or exactly one-hot in every cycle. The bench checks `$onehot0(grant)`.
- **Reset mid-operation:** `rst` overrides everything in the same edge, including `done` and any pending timeout. All registers return to their reset values.

## Timing
- **Arbitration latency:** `req` seen in IDLE at edge n gives `grant` valid after edge n, i.e. 1 cycle.
- **Release latency:** `done` seen at edge m clears `grant` after edge m.
- **Minimum spacing:** back-to-back grants are 2 cycles apart. IDLE always lasts at least 1 cycle, and `grant` is 0 during it.
- **Downstream encoder:** the encoder output is combinational from `grant`, so the encoded code is valid in the same cycle as `grant_valid`.
- **Simultaneous `done` and `req` change:** `done` takes effect. The new `req` is evaluated in the following IDLE cycle.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit watchdog counts cycles spent in GRANT without `done`. It clears on entry to GRANT.
  - When the count reaches `TIMEOUT_CYCLES` with `done`=0, the arbiter releases the grant exactly as for `done` (pointer advances, return to IDLE) and pulses `timeout` for 1 cycle, coincident with the IDLE cycle.
  - If `done` and timeout expiry coincide, it is treated as `done` and no `timeout` pulse is issued.
- **Undefined:** no counter, `timeout` is tied 0, and a grant is held indefinitely until `done`.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ`=8 and `PTR_W`=3.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Default `TIMEOUT_CYCLES`.
- **Sub-module `rr_pick`:** combinational. Inputs `req[7:0]`, `ptr[2:0]`; outputs `winner[2:0]` and `any`. It rotates `req` right by `ptr`, applies a fixed-priority scan, and adds `ptr` back mod 8.
- The top level holds the FSM, pointer, grant register and the optional watchdog.

## Test plan
- **Reset:** assert `rst` with `req`=8'hFF and `done`=1 for 2 cycles → `grant`=0, `grant_valid`=0, `timeout`=0; first grant after release = 8'h01.
- **Full rotation:** `req`=8'hFF held, `done` pulsed 1 cycle after each grant → grants 01,02,04,…,80,01 with one idle cycle between each.
- **Sparse wrap:** `ptr`=6 (after serving 5), `req`=8'h21 → grant 8'h01 (bit 5 is skipped because bit 0 follows 7), then 8'h20.
- **Hold:** `req` 8'h08 granted, then `req` drops to 8'h00 and 8'h10 rises → `grant` stays 8'h08 until `done`; next grant is 8'h10.
- **Mid-grant reset:** `grant`=8'h04, assert `rst` → next cycle `grant`=0 and `ptr`=0; with `req`=8'h05 the next grant is 8'h01.
- **Watchdog** (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):
  - Grant 8'h02 with `done` never asserted → release after 4 GRANT cycles, 1-cycle `timeout` pulse, next grant 8'h04 if requested.
  - Without the macro, the same stimulus holds 8'h02 for 100 cycles and `timeout` stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int PTR_W = 3;
    localparam int TIMEOUT_CYCLES_DEFAULT = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select starting at ptr
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_any
);
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]   w_idx;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_idx = PTR_W'(i);
        end
    end

    assign o_winner = w_idx + i_ptr;
    assign o_any    = |i_req;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - 8-way round-robin arbiter with held one-hot grant; watchdog under ARB_TIMEOUT_EN
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_grant_valid,
    output logic             o_timeout
);
    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_idx;
    logic [N_REQ-1:0] r_grant;
    logic             r_timeout;
    logic [PTR_W-1:0] w_winner;
    logic             w_any;
    logic             w_expire;
    logic             w_release;

    rr_pick u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wdog;

    // A coincident done wins, so expiry only counts when done is low.
    assign w_expire = (r_state == GRANT) && !i_done && (r_wdog == WD_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == IDLE) r_wdog <= 8'd0;
        else                          r_wdog <= r_wdog + 8'd1;
    end
`else
    assign w_expire = 1'b0;
`endif

    assign w_release = (r_state == GRANT) && (i_done || w_expire);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = GRANT;
            GRANT:   if (w_release) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_grant <= N_REQ'(1) << w_winner;
                r_idx   <= w_winner;
            end else if (w_release) begin
                r_grant   <= '0;
                r_ptr     <= r_idx + PTR_W'(1);
                r_timeout <= w_expire;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = |r_grant;
    assign o_timeout     = r_timeout;
endmodule
